// File: rtl/sha_target_checker_if.sv
// Bundle between the double-hash pipeline / host and the target checker.
//   start          : one-cycle pulse, arms the checker and loads nonce_base
//   nonce_base     : nonce of the first hash produced after start
//   target         : 256-bit big-endian difficulty target, stable while busy
//   hash           : final hash words, hash[k] = h_k (h0..h7)
//   hash_valid     : one-cycle pulse, hash is valid
//   busy           : armed and searching
//   found          : one-cycle pulse, a winning nonce was identified
//   found_nonce    : winning nonce, held until the next start or reset
//   hashes_checked : completed comparisons since start (wraps)
//   overflow       : sticky, a hash was dropped because the FIFO was full
// master = producer side, slave = the checker.
interface sha_target_checker_if #(
  parameter int NONCE_WIDTH = 32
);
  logic                   start;
  logic [NONCE_WIDTH-1:0] nonce_base;
  logic [255:0]           target;
  logic [7:0][31:0]       hash;
  logic                   hash_valid;
  logic                   busy;
  logic                   found;
  logic [NONCE_WIDTH-1:0] found_nonce;
  logic [31:0]            hashes_checked;
  logic                   overflow;

  modport master (
    output start, nonce_base, target, hash, hash_valid,
    input  busy, found, found_nonce, hashes_checked, overflow
  );

  modport slave (
    input  start, nonce_base, target, hash, hash_valid,
    output busy, found, found_nonce, hashes_checked, overflow
  );
endinterface

// File: rtl/sha_target_checker.sv
// sha_target_checker
// Tags each final hash with its nonce, buffers it in a small FIFO and compares
// the Bitcoin-ordered 256-bit value V = {bswap(h7),...,bswap(h0)} against the
// target one 32-bit word per cycle, most significant word first. Reports the
// first nonce with V <= target and then stops until the next start.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : sha_target_checker_if.slave (see interface file for signal list)
//
// state  | meaning
// IDLE   | waiting; pops the FIFO head and compares its top word in the same cycle
// LOAD   | one-cycle bubble after a pop, only used when FIFO_DEPTH > 2
// CMP    | comparing word k of the working entry, k counts down
// REPORT | one cycle: bump hashes_checked, pulse found if the entry met target
module sha_target_checker #(
  parameter int FIFO_DEPTH  = 2,
  parameter int NONCE_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  sha_target_checker_if.slave bus
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam bit              REG_READ = (FIFO_DEPTH > 2);

  typedef enum logic [1:0] {IDLE, LOAD, CMP, REPORT} state_t;

  state_t                 state_q, state_d;

  logic [7:0][31:0]       fifo_hash  [FIFO_DEPTH];
  logic [NONCE_WIDTH-1:0] fifo_nonce [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic                   fifo_empty, fifo_full;

  logic [7:0][31:0]       work_hash;
  logic [NONCE_WIDTH-1:0] work_nonce;
  logic [NONCE_WIDTH-1:0] nonce_cnt;
  logic [2:0]             k_q, k_d;
  logic                   meets_q, meets_d;

  logic                   busy_q;
  logic [NONCE_WIDTH-1:0] found_nonce_q;
  logic [31:0]            checked_q;
  logic                   overflow_q;

  logic                   push_req, push_ok, pop, win_decided;
  logic [31:0]            cur_word, cur_tgt;
  logic [NONCE_WIDTH-1:0] cur_nonce;
  logic                   word_lt, word_gt;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // Hashes arriving while not armed are ignored and do not advance the nonce.
  assign push_req = bus.hash_valid && busy_q;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok  = push_req && (!fifo_full || pop);

  // With the small FIFO the head is read directly, so IDLE compares the top
  // word of the head while popping it; this is what gives REPORT at t+1+n.
  always_comb begin
    cur_word  = bswap(work_hash[k_q]);
    cur_tgt   = bus.target[{k_q, 5'd0} +: 32];
    cur_nonce = work_nonce;
    if (state_q == IDLE) begin
      cur_word  = bswap(fifo_hash[rd_ptr][7]);
      cur_tgt   = bus.target[255:224];
      cur_nonce = fifo_nonce[rd_ptr];
    end
  end

  assign word_lt = (cur_word < cur_tgt);
  assign word_gt = (cur_word > cur_tgt);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    meets_d     = meets_q;
    pop         = 1'b0;
    win_decided = 1'b0;
    case (state_q)
      IDLE: begin
        if (busy_q && !fifo_empty) begin
          pop = 1'b1;
          if (REG_READ) begin
            state_d = LOAD;
          end else if (word_lt) begin
            meets_d     = 1'b1;
            win_decided = 1'b1;
            state_d     = REPORT;
          end else if (word_gt) begin
            meets_d = 1'b0;
            state_d = REPORT;
          end else begin
            k_d     = 3'd6;
            state_d = CMP;
          end
        end
      end
      LOAD: begin
        k_d     = 3'd7;
        state_d = CMP;
      end
      CMP: begin
        if (word_lt || (!word_gt && k_q == 3'd0)) begin
          meets_d     = 1'b1;
          win_decided = 1'b1;
          state_d     = REPORT;
        end else if (word_gt) begin
          meets_d = 1'b0;
          state_d = REPORT;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      REPORT: begin
        meets_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst && !bus.start) begin
      fifo_hash[wr_ptr]  <= bus.hash;
      fifo_nonce[wr_ptr] <= nonce_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      work_hash     <= '0;
      work_nonce    <= '0;
      nonce_cnt     <= '0;
      k_q           <= 3'd7;
      meets_q       <= 1'b0;
      busy_q        <= 1'b0;
      found_nonce_q <= '0;
      checked_q     <= '0;
      overflow_q    <= 1'b0;
    end else if (bus.start) begin
      // A simultaneous hash_valid is deliberately lost here without overflow.
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      nonce_cnt     <= bus.nonce_base;
      k_q           <= 3'd7;
      meets_q       <= 1'b0;
      busy_q        <= 1'b1;
      found_nonce_q <= '0;
      checked_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      k_q     <= k_d;
      meets_q <= meets_d;

      if (push_req) begin
        nonce_cnt <= nonce_cnt + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push_req && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        work_hash  <= fifo_hash[rd_ptr];
        work_nonce <= fifo_nonce[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Latch the winner as soon as it is decided so found_nonce is already
      // valid during the found pulse.
      if (win_decided) begin
        found_nonce_q <= cur_nonce;
      end

      if (state_q == REPORT) begin
        checked_q <= checked_q + 32'd1;
        if (meets_q) begin
          busy_q <= 1'b0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.found          = (state_q == REPORT) && meets_q;
  assign bus.found_nonce    = found_nonce_q;
  assign bus.hashes_checked = checked_q;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_sha_target_checker.sv
module tb_sha_target_checker;

  typedef logic [7:0][31:0] hash_t;
  typedef struct {
    bit          meets;
    logic [31:0] nonce;
    int          rpt_cyc;
    bit          lat_ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sha_target_checker_if #(.NONCE_WIDTH(32)) bus ();

  sha_target_checker #(.FIFO_DEPTH(2), .NONCE_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t        sb[$];
  bit          model_busy   = 1'b0;
  logic [31:0] model_nonce  = '0;
  bit          pend         = 1'b0;
  logic [31:0] pend_nonce   = '0;
  int          pend_cyc     = 0;
  bit          chk_busy     = 1'b0;
  logic [31:0] prev_checked = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [255:0] value_of(input hash_t h);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = bswap(h[k]);
    return v;
  endfunction

  // Number of words a most-significant-first comparison has to look at.
  function automatic int words_examined(input hash_t h, input logic [255:0] t);
    logic [255:0] v;
    v = value_of(h);
    for (int k = 7; k >= 0; k--) begin
      if (v[32*k +: 32] != t[32*k +: 32]) return 8 - k;
    end
    return 8;
  endfunction

  function automatic hash_t rand_hash();
    hash_t h;
    for (int k = 0; k < 8; k++) h[k] = $urandom;
    return h;
  endfunction

  function automatic hash_t equal_hash(input logic [255:0] t);
    hash_t h;
    for (int k = 0; k < 8; k++) h[k] = bswap(t[32*k +: 32]);
    return h;
  endfunction

  function automatic void model_capture(input hash_t h, input bit drop, input bit lat_ok);
    exp_t e;
    bit   meets;
    if (!model_busy) return;
    meets = (value_of(h) <= bus.target);
    if (!drop) begin
      e.meets   = meets;
      e.nonce   = model_nonce;
      e.rpt_cyc = cyc + 1 + words_examined(h, bus.target);
      e.lat_ok  = lat_ok;
      sb.push_back(e);
      if (meets) model_busy = 1'b0;
    end
    model_nonce = model_nonce + 32'd1;
  endfunction

  // Called just after a rising edge; occupies exactly one cycle.
  task automatic drive(input bit st, input bit hv, input hash_t h, input bit drop, input bit lat_ok);
    bus.start      = st;
    bus.hash_valid = hv;
    bus.hash       = h;
    if (st) begin
      model_busy  = 1'b1;
      model_nonce = bus.nonce_base;
    end else if (hv) begin
      model_capture(h, drop, lat_ok);
    end
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.hash_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [255:0] t);
    bus.nonce_base = base;
    bus.target     = t;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((sb.size() != 0 || pend) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_queue", sb.size(), 0);
    chk("drain_found_pending", pend, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_busy = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_found"}, bus.found, 0);
    chk({tag, "_found_nonce"}, bus.found_nonce, 0);
    chk({tag, "_hashes_checked"}, bus.hashes_checked, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
  endtask

  // Monitor: every completed comparison (hashes_checked step) consumes one
  // expected entry; a found pulse in the preceding cycle must match it.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend         = 1'b0;
      chk_busy     = 1'b0;
      prev_checked = '0;
    end else begin
      if (chk_busy) begin
        chk("busy_after_found", bus.busy, 0);
        chk_busy = 1'b0;
      end
      if (bus.hashes_checked == prev_checked + 32'd1) begin
        chk("report_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("report_meets", pend, e.meets);
          if (e.meets) begin
            chk("found_nonce", pend_nonce, e.nonce);
            if (e.lat_ok) chk("found_latency", pend_cyc, e.rpt_cyc);
          end
          if (e.lat_ok) chk("report_latency", cyc, e.rpt_cyc + 1);
        end
        pend         = 1'b0;
        prev_checked = bus.hashes_checked;
      end else if (bus.hashes_checked != prev_checked) begin
        if (bus.hashes_checked != 0) chk("hashes_checked_step", bus.hashes_checked, prev_checked + 32'd1);
        prev_checked = bus.hashes_checked;
      end
      if (bus.found) begin
        pend       = 1'b1;
        pend_nonce = bus.found_nonce;
        pend_cyc   = cyc;
        chk_busy   = 1'b1;
      end
    end
  end

  initial begin
    hash_t        h;
    logic [255:0] t;
    logic [31:0]  b;

    bus.start      = 1'b0;
    bus.hash_valid = 1'b0;
    bus.hash       = '0;
    bus.nonce_base = '0;
    bus.target     = '0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // all-ones target, one-word decision
    do_start(32'h10, '1);
    h = rand_hash();
    h[7] = 32'h0000_0001;
    drive(1'b0, 1'b1, h, 1'b0, 1'b1);
    wait_drain(40);
    chk("t1_found_nonce", bus.found_nonce, 32'h10);
    chk("t1_hashes_checked", bus.hashes_checked, 1);
    chk("t1_busy", bus.busy, 0);

    // leading zero word target, widely spaced hashes
    do_start(32'd5, {32'h0, {224{1'b1}}});
    for (int i = 0; i < 3; i++) begin
      h = rand_hash();
      h[7] = (i < 2) ? 32'h0100_0000 : 32'h0;
      drive(1'b0, 1'b1, h, 1'b0, 1'b1);
      idle(99);
    end
    wait_drain(40);
    chk("t2_found_nonce", bus.found_nonce, 32'd7);
    chk("t2_hashes_checked", bus.hashes_checked, 3);

    // V equal to target, then V just above target
    for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
    if (t[31:0] == 32'hFFFF_FFFF) t[31:0] = 32'h0;
    do_start($urandom, t);
    drive(1'b0, 1'b1, equal_hash(t), 1'b0, 1'b1);
    wait_drain(40);
    chk("t3_eq_hashes_checked", bus.hashes_checked, 1);
    do_start($urandom, t);
    h = equal_hash(t);
    h[0] = bswap(t[31:0] + 32'd1);
    drive(1'b0, 1'b1, h, 1'b0, 1'b1);
    wait_drain(40);
    chk("t3_gt_hashes_checked", bus.hashes_checked, 1);
    chk("t3_gt_found_nonce", bus.found_nonce, 0);
    chk("t3_gt_busy", bus.busy, 1);

    // overflow: a long compare followed by a back-to-back burst
    for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom_range(0, 32'hFFFF_FFFE);
    b = $urandom;
    do_start(b, t);
    h = equal_hash(t);
    h[0] = bswap(t[31:0] + 32'd1);
    drive(1'b0, 1'b1, h, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      h = rand_hash();
      h[7] = bswap(t[255:224] + 32'd1);
      drive(1'b0, 1'b1, h, (i == 2), 1'b0);
    end
    wait_drain(60);
    chk("burst_overflow", bus.overflow, 1);
    chk("burst_hashes_checked", bus.hashes_checked, 3);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
    wait_drain(40);
    chk("burst_nonce_advance", bus.found_nonce, b + 32'd4);
    chk("burst_overflow_sticky", bus.overflow, 1);

    pulse_reset();
    check_zero("post_run_reset");

    // nonce wrap
    for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom_range(0, 32'hFFFF_FFFE);
    do_start(32'hFFFF_FFFF, t);
    h = rand_hash();
    h[7] = bswap(t[255:224] + 32'd1);
    drive(1'b0, 1'b1, h, 1'b0, 1'b1);
    idle(13);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
    wait_drain(40);
    chk("wrap_found_nonce", bus.found_nonce, 32'h0);

    // start together with hash_valid: hash dropped, no overflow
    b = $urandom;
    bus.nonce_base = b;
    bus.target     = '1;
    drive(1'b1, 1'b1, '0, 1'b0, 1'b0);
    idle(5);
    chk("simul_hashes_checked", bus.hashes_checked, 0);
    chk("simul_overflow", bus.overflow, 0);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b1);
    wait_drain(40);
    chk("simul_found_nonce", bus.found_nonce, b);

    // reset in the middle of a compare
    for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
    do_start($urandom, t);
    drive(1'b0, 1'b1, equal_hash(t), 1'b0, 1'b1);
    idle(3);
    pulse_reset();
    check_zero("mid_cmp_reset");
    idle(15);
    chk("mid_cmp_no_report", bus.hashes_checked, 0);
    chk("mid_cmp_no_found", pend, 0);

    // randomized rounds; round 0 uses the all-zero target
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) t[32*k +: 32] = (r == 0) ? 32'h0 : $urandom;
      do_start($urandom, t);
      for (int i = 0; i < 5; i++) begin
        int j;
        h = rand_hash();
        j = $urandom_range(0, 8);
        for (int k = 7; k >= 8 - j; k--) h[k] = bswap(t[32*k +: 32]);
        if (r == 0 && i == 4) h = '0;
        drive(1'b0, 1'b1, h, 1'b0, 1'b1);
        idle(13);
      end
      wait_drain(40);
    end

    chk("final_queue_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
